// File: rtl/fifo_tx_sync_v2.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_tx_sync_v2
//  Brief   : Single-clock TX FIFO, EMB-backed, with level/flags/flush/rvalid.
//            Optional sticky overflow/underflow ports via FIFO_TX_SYNC_V2_ERR_EN.
//  Revision: 2.0
// ============================================================================
module fifo_tx_sync_v2 #(
  parameter int DW        = 32,
  parameter int AW        = 10,
  parameter int AFULL_TH  = 2**AW - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wdata,
  output logic          full,
  output logic          afull,
  input  logic          rd_en,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          empty,
  output logic          aempty,
  output logic [AW:0]   level
`ifdef FIFO_TX_SYNC_V2_ERR_EN
  ,
  output logic          overflow,
  output logic          underflow
`endif
);

  localparam int          DEPTH      = 1 << AW;
  localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull_th
    $error("fifo_tx_sync_v2: AFULL_TH=%0d outside 1..%0d", AFULL_TH, DEPTH);
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty_th
    $error("fifo_tx_sync_v2: AEMPTY_TH=%0d outside 0..%0d", AEMPTY_TH, DEPTH - 1);
  end

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q;

  logic wa, ra, wr_fire, rd_fire;

  // Accepts are gated by the registered flags only, so full/empty never bypass.
  assign wa      = wr_en & ~full_q;
  assign ra      = rd_en & ~empty_q;
  assign wr_fire = wa & rstn & ~flush;
  assign rd_fire = ra & rstn & ~flush;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    rvalid_d = 1'b0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wa) wptr_d = wptr_q + 1'b1;
      if (ra) rptr_d = rptr_q + 1'b1;
      level_d  = level_q + {{AW{1'b0}}, wa} - {{AW{1'b0}}, ra};
      rvalid_d = ra;
    end
    // Flags derive from the next level so they always agree with it.
    empty_d  = (level_d == '0);
    full_d   = (level_d == FULL_LVL);
    afull_d  = (level_d >= AFULL_LVL);
    aempty_d = (level_d <= AEMPTY_LVL);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) rdata_q <= '0;
    else if (rd_fire) rdata_q <= mem[rptr_q];
  end

  assign full   = full_q;
  assign afull  = afull_q;
  assign empty  = empty_q;
  assign aempty = aempty_q;
  assign level  = level_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

`ifdef FIFO_TX_SYNC_V2_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en & full_q)  overflow_d  = 1'b1;
      if (rd_en & empty_q) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_sync_v2.sv
`default_nettype none
// Directed bench for fifo_tx_sync_v2 at DW=32, AW=4, AFULL_TH=12, AEMPTY_TH=4.
module tb_fifo_tx_sync_v2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic        full, afull, rvalid, empty, aempty;
  logic [31:0] rdata;
  logic [4:0]  level;
`ifdef FIFO_TX_SYNC_V2_ERR_EN
  logic        overflow, underflow;
`endif

  int tests = 0;
  int errors = 0;

  fifo_tx_sync_v2 #(.DW(32), .AW(4), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .wr_en(wr_en), .wdata(wdata), .full(full), .afull(afull),
    .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid),
    .empty(empty), .aempty(aempty), .level(level)
`ifdef FIFO_TX_SYNC_V2_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick(); tick(); tick();
    tests++;
    if ({empty, aempty, full, afull} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags got %b exp 1100", {empty, aempty, full, afull});
    end
    tests++;
    if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    tests++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
    tests++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wdata = 32'h100 + 32'(i);
      tick();
      tests++;
      if (level !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_level i=%0d got %0d exp %0d", i, level, i + 1);
      end
      tests++;
      if (afull !== ((i + 1) >= 12)) begin
        errors++; $display("FAIL fill_afull lvl=%0d got %b exp %b", i + 1, afull, (i + 1) >= 12);
      end
      tests++;
      if (aempty !== ((i + 1) <= 4)) begin
        errors++; $display("FAIL fill_aempty lvl=%0d got %b exp %b", i + 1, aempty, (i + 1) <= 4);
      end
      tests++;
      if ({full, empty} !== {((i + 1) == 16), 1'b0}) begin
        errors++; $display("FAIL fill_full_empty lvl=%0d got %b", i + 1, {full, empty});
      end
    end
    wdata = 32'hDEAD;
    tick();
    wr_en = 1'b0;
    tests++;
    if (level !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL overflow_drop got level=%0d full=%b exp 16/1", level, full);
    end
`ifdef FIFO_TX_SYNC_V2_ERR_EN
    tests++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got %b exp 1", overflow); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      tests++;
      if (rvalid !== 1'b1 || rdata !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL drain_data i=%0d got v=%b %h exp 1 %h", i, rvalid, rdata, 32'h100 + 32'(i));
      end
      tests++;
      if (level !== 5'(15 - i)) begin
        errors++; $display("FAIL drain_level i=%0d got %0d exp %0d", i, level, 15 - i);
      end
    end
    tests++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL drain_empty got empty=%b full=%b exp 1/0", empty, full);
    end
    tick();
    rd_en = 1'b0;
    tests++;
    if (rvalid !== 1'b0 || rdata !== 32'h10F) begin
      errors++; $display("FAIL underflow_read got v=%b %h exp 0 0000010f", rvalid, rdata);
    end
`ifdef FIFO_TX_SYNC_V2_ERR_EN
    tests++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag got %b exp 1", underflow); end
`endif
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wdata = 32'h200 + 32'(k);
      tick();
    end
    tests++;
    if (level !== 5'd8) begin errors++; $display("FAIL b2b_prefill got %0d exp 8", level); end
    for (int j = 0; j < 40; j++) begin
      wr_en = 1'b1; rd_en = 1'b1; wdata = 32'h208 + 32'(j);
      tick();
      tests++;
      if (level !== 5'd8) begin errors++; $display("FAIL b2b_level j=%0d got %0d exp 8", j, level); end
      tests++;
      if (rvalid !== 1'b1 || rdata !== 32'h200 + 32'(j)) begin
        errors++; $display("FAIL b2b_data j=%0d got v=%b %h exp 1 %h", j, rvalid, rdata, 32'h200 + 32'(j));
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    wr_en = 1'b1; wdata = 32'h300; tick();
    wdata = 32'h301; tick();
    wr_en = 1'b0;
    tests++;
    if (level !== 5'd10) begin errors++; $display("FAIL flush_prelevel got %0d exp 10", level); end
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wdata = 32'hBEEF;
    tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tests++;
    if (level !== 5'd0 || {empty, aempty, full, afull} !== 4'b1100) begin
      errors++; $display("FAIL flush_state got level=%0d flags=%b exp 0/1100", level, {empty, aempty, full, afull});
    end
    tests++;
    if (rvalid !== 1'b0 || rdata !== 32'h227) begin
      errors++; $display("FAIL flush_rdata got v=%b %h exp 0 00000227", rvalid, rdata);
    end
`ifdef FIFO_TX_SYNC_V2_ERR_EN
    tests++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++; $display("FAIL flush_err_clear got %b exp 00", {overflow, underflow});
    end
`endif
    wr_en = 1'b1; wdata = 32'hA5; tick();
    wr_en = 1'b0;
    tests++;
    if (level !== 5'd1) begin errors++; $display("FAIL flush_write got level %0d exp 1", level); end
    rd_en = 1'b1; tick();
    rd_en = 1'b0;
    tests++;
    if (rvalid !== 1'b1 || rdata !== 32'hA5) begin
      errors++; $display("FAIL flush_readback got v=%b %h exp 1 000000a5", rvalid, rdata);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wdata = 32'h400 + 32'(k);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    tests++;
    if (level !== 5'd7 || rvalid !== 1'b1 || rdata !== 32'h400) begin
      errors++; $display("FAIL mid_read got level=%0d v=%b %h exp 7 1 00000400", level, rvalid, rdata);
    end
    rstn = 1'b0; wr_en = 1'b1; wdata = 32'h999;
    tick();
    tests++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || level !== 5'd0) begin
      errors++; $display("FAIL mid_reset got v=%b %h level=%0d exp 0 0 0", rvalid, rdata, level);
    end
    tests++;
    if ({empty, aempty, full, afull} !== 4'b1100) begin
      errors++; $display("FAIL mid_reset_flags got %b exp 1100", {empty, aempty, full, afull});
    end
    rstn = 1'b1; rd_en = 1'b0; wdata = 32'h55;
    tick();
    wr_en = 1'b0;
    tests++;
    if (level !== 5'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL resume_write got level=%0d empty=%b exp 1/0", level, empty);
    end
    rd_en = 1'b1; tick();
    rd_en = 1'b0;
    tests++;
    if (rvalid !== 1'b1 || rdata !== 32'h55 || empty !== 1'b1) begin
      errors++; $display("FAIL resume_read got v=%b %h empty=%b exp 1 00000055 1", rvalid, rdata, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
